// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flow controller for a five-stage in-order pipeline.
// Produces PC control, per-register enable/flush, and stall/redirect counters.
module pipe_hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ibus_ack_i,
    input  logic        dbus_req_i,
    input  logic        dbus_ack_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_is_load_i,
    input  logic        branch_taken_ex_i,
    input  logic        trap_wb_i,
    output logic        pc_en_o,
    output logic [1:0]  pc_sel_o,
    output logic        if_id_en_o,
    output logic        if_id_clear_o,
    output logic        id_ex_en_o,
    output logic        id_ex_clear_o,
    output logic        ex_mem_en_o,
    output logic        ex_mem_clear_o,
    output logic        mem_wb_en_o,
    output logic        mem_wb_clear_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o,
    output logic [7:0]  flush_cnt_o
);

    localparam logic [1:0] RUN    = 2'b00;
    localparam logic [1:0] DWAIT  = 2'b01;
    localparam logic [1:0] TFLUSH = 2'b10;

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_TRAP = 2'b10;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]  state_q, state_d, cur_state;
    logic [15:0] stall_q, stall_d;
    logic [7:0]  flush_q, flush_d;

    logic        load_use, dbus_wait, flush_evt;
    logic        pc_en_r;
    logic [1:0]  pc_sel_r;
    logic        if_id_en_r, if_id_clr_r;
    logic        id_ex_en_r, id_ex_clr_r;
    logic        ex_mem_en_r, ex_mem_clr_r;
    logic        mem_wb_en_r, mem_wb_clr_r;

    // The unused encoding 11 behaves exactly like RUN and returns there.
    assign cur_state = (state_q == DWAIT || state_q == TFLUSH) ? state_q : RUN;

    assign load_use = ex_is_load_i && (ex_rd_i != 5'd0) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    assign dbus_wait = dbus_req_i && !dbus_ack_i;

    always_comb begin
        pc_en_r      = 1'b1;
        pc_sel_r     = SEL_SEQ;
        if_id_en_r   = 1'b1;
        if_id_clr_r  = 1'b0;
        id_ex_en_r   = 1'b1;
        id_ex_clr_r  = 1'b0;
        ex_mem_en_r  = 1'b1;
        ex_mem_clr_r = 1'b0;
        mem_wb_en_r  = 1'b1;
        mem_wb_clr_r = 1'b0;
        flush_evt    = 1'b0;
        state_d      = RUN;

        if (trap_wb_i) begin
            pc_sel_r     = SEL_TRAP;
            if_id_clr_r  = 1'b1;
            id_ex_clr_r  = 1'b1;
            ex_mem_clr_r = 1'b1;
            mem_wb_clr_r = 1'b1;
            flush_evt    = 1'b1;
            state_d      = TFLUSH;
        end else if (cur_state != TFLUSH && dbus_wait) begin
            // Freeze everything up to MEM; WB receives a bubble.
            pc_en_r      = 1'b0;
            if_id_en_r   = 1'b0;
            id_ex_en_r   = 1'b0;
            ex_mem_en_r  = 1'b0;
            mem_wb_clr_r = 1'b1;
            state_d      = DWAIT;
        end else if (cur_state == TFLUSH) begin
            if (!ibus_ack_i) begin
                pc_en_r     = 1'b0;
                if_id_clr_r = 1'b1;
                state_d     = TFLUSH;
            end
        end else if (branch_taken_ex_i) begin
            pc_sel_r    = SEL_BR;
            if_id_clr_r = 1'b1;
            id_ex_clr_r = 1'b1;
            flush_evt   = 1'b1;
        end else if (load_use) begin
            pc_en_r     = 1'b0;
            if_id_en_r  = 1'b0;
            id_ex_clr_r = 1'b1;
        end else if (!ibus_ack_i) begin
            pc_en_r     = 1'b0;
            if_id_clr_r = 1'b1;
        end
    end

    assign stall_d = pc_en_r   ? stall_q : sat_inc16(stall_q);
    assign flush_d = flush_evt ? sat_inc8(flush_q) : flush_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            stall_q <= 16'd0;
            flush_q <= 8'd0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Reset overrides every control output; a clear always wins over its enable.
    always_comb begin
        if (!rst_ni) begin
            pc_en_o        = 1'b0;
            pc_sel_o       = SEL_SEQ;
            if_id_en_o     = 1'b0;
            if_id_clear_o  = 1'b1;
            id_ex_en_o     = 1'b0;
            id_ex_clear_o  = 1'b1;
            ex_mem_en_o    = 1'b0;
            ex_mem_clear_o = 1'b1;
            mem_wb_en_o    = 1'b0;
            mem_wb_clear_o = 1'b1;
        end else begin
            pc_en_o        = pc_en_r;
            pc_sel_o       = pc_sel_r;
            if_id_en_o     = if_id_en_r  && !if_id_clr_r;
            if_id_clear_o  = if_id_clr_r;
            id_ex_en_o     = id_ex_en_r  && !id_ex_clr_r;
            id_ex_clear_o  = id_ex_clr_r;
            ex_mem_en_o    = ex_mem_en_r && !ex_mem_clr_r;
            ex_mem_clear_o = ex_mem_clr_r;
            mem_wb_en_o    = mem_wb_en_r && !mem_wb_clr_r;
            mem_wb_clear_o = mem_wb_clr_r;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ibus_ack, dbus_req, dbus_ack;
    logic [4:0]  rs1, rs2, ex_rd;
    logic        use1, use2, ex_load, branch, trap;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic        if_id_en, if_id_clr, id_ex_en, id_ex_clr;
    logic        ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [7:0]  flush_cnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ibus_ack_i(ibus_ack), .dbus_req_i(dbus_req), .dbus_ack_i(dbus_ack),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
        .ex_rd_i(ex_rd), .ex_is_load_i(ex_load),
        .branch_taken_ex_i(branch), .trap_wb_i(trap),
        .pc_en_o(pc_en), .pc_sel_o(pc_sel),
        .if_id_en_o(if_id_en), .if_id_clear_o(if_id_clr),
        .id_ex_en_o(id_ex_en), .id_ex_clear_o(id_ex_clr),
        .ex_mem_en_o(ex_mem_en), .ex_mem_clear_o(ex_mem_clr),
        .mem_wb_en_o(mem_wb_en), .mem_wb_clear_o(mem_wb_clr),
        .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    // {pc_en, pc_sel, if_id en/clr, id_ex en/clr, ex_mem en/clr, mem_wb en/clr}
    logic [10:0] dut_vec;
    assign dut_vec = {pc_en, pc_sel, if_id_en, if_id_clr, id_ex_en, id_ex_clr,
                      ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr};

    localparam logic [10:0] V_RESET = 11'b0_00_01_01_01_01;
    localparam logic [10:0] V_TRAP  = 11'b1_10_01_01_01_01;
    localparam logic [10:0] V_DBUS  = 11'b0_00_00_00_00_01;
    localparam logic [10:0] V_IWAIT = 11'b0_00_01_10_10_10;
    localparam logic [10:0] V_DEF   = 11'b1_00_10_10_10_10;
    localparam logic [10:0] V_BR    = 11'b1_01_01_01_10_10;
    localparam logic [10:0] V_LU    = 11'b0_00_00_01_10_10;

    typedef enum int {R_RESET, R_TRAP, R_DBUS, R_TFWAIT, R_TFGO,
                      R_BRANCH, R_LU, R_IBUS, R_DEF} rule_t;

    // Reference model state: 0 = RUN, 1 = DWAIT, 2 = TFLUSH
    int m_state = 0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic rule_t cur_rule();
        bit lu;
        lu = ex_load && (ex_rd != 0) && ((use1 && rs1 == ex_rd) || (use2 && rs2 == ex_rd));
        if (!rst_n) return R_RESET;
        if (trap) return R_TRAP;
        if (m_state != 2 && dbus_req && !dbus_ack) return R_DBUS;
        if (m_state == 2) return ibus_ack ? R_TFGO : R_TFWAIT;
        if (branch) return R_BRANCH;
        if (lu) return R_LU;
        if (!ibus_ack) return R_IBUS;
        return R_DEF;
    endfunction

    function automatic logic [10:0] rule_vec(input rule_t r);
        case (r)
            R_RESET:         return V_RESET;
            R_TRAP:          return V_TRAP;
            R_DBUS:          return V_DBUS;
            R_TFWAIT, R_IBUS: return V_IWAIT;
            R_BRANCH:        return V_BR;
            R_LU:            return V_LU;
            default:         return V_DEF;
        endcase
    endfunction

    task automatic idle();
        ibus_ack = 1'b1; dbus_req = 1'b0; dbus_ack = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; use1 = 1'b0; use2 = 1'b0;
        ex_rd = 5'd0; ex_load = 1'b0; branch = 1'b0; trap = 1'b0;
    endtask

    // Advance one clock and update the model with the rule in effect before the edge.
    task automatic tick();
        rule_t r;
        r = cur_rule();
        @(posedge clk);
        #1;
        if (r == R_RESET) begin
            m_state = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (r == R_TRAP || r == R_TFWAIT) m_state = 2;
            else if (r == R_DBUS)             m_state = 1;
            else                              m_state = 0;
            if (r == R_DBUS || r == R_TFWAIT || r == R_IBUS || r == R_LU)
                m_stall = (m_stall == 65535) ? 65535 : m_stall + 1;
            if (r == R_TRAP || r == R_BRANCH)
                m_flush = (m_flush == 255) ? 255 : m_flush + 1;
        end
    endtask

    task automatic do_reset();
        idle();
        @(posedge clk);
        #3 rst_n = 1'b0;
        m_state = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec !== V_RESET) $display("FAIL reset_outputs: got %b expected %b", dut_vec, V_RESET);
        else passes++;
        checks++;
        if (state !== 2'b00 || stall_cnt !== 16'd0 || flush_cnt !== 8'd0)
            $display("FAIL reset_regs: got state=%b stall=%0d flush=%0d expected 00/0/0", state, stall_cnt, flush_cnt);
        else passes++;
        rst_n = 1'b1;
        m_state = 0; m_stall = 0; m_flush = 0;
        #1;
        checks++;
        if (dut_vec !== V_DEF) $display("FAIL after_release: got %b expected %b", dut_vec, V_DEF);
        else passes++;
    endtask

    task automatic test_dbus_wait();
        idle();
        dbus_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_wb_clr !== 1'b1 || dut_vec !== V_DBUS)
                $display("FAIL dbus_wait_out[%0d]: got %b expected %b", i, dut_vec, V_DBUS);
            else passes++;
            tick();
            checks++;
            if (state !== 2'b01) $display("FAIL dbus_state[%0d]: got %b expected 01", i, state);
            else passes++;
        end
        dbus_ack = 1'b1;
        #1;
        checks++;
        if (dut_vec !== V_DEF) $display("FAIL dbus_ack_out: got %b expected %b", dut_vec, V_DEF);
        else passes++;
        tick();
        checks++;
        if (state !== 2'b00 || stall_cnt !== 16'd3)
            $display("FAIL dbus_done: got state=%b stall=%0d expected 00/3", state, stall_cnt);
        else passes++;
        idle();
    endtask

    task automatic test_load_use();
        logic [15:0] s0;
        idle();
        ex_load = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
        s0 = stall_cnt;
        #1;
        checks++;
        if (pc_en !== 1'b0 || if_id_en !== 1'b0 || id_ex_clr !== 1'b1 || dut_vec !== V_LU)
            $display("FAIL load_use_out: got %b expected %b", dut_vec, V_LU);
        else passes++;
        tick();
        checks++;
        if (stall_cnt !== s0 + 16'd1) $display("FAIL load_use_stall: got %0d expected %0d", stall_cnt, s0 + 16'd1);
        else passes++;
    endtask

    task automatic test_rd_zero();
        logic [15:0] s0;
        idle();
        ex_load = 1'b1; ex_rd = 5'd0; rs1 = 5'd0; use1 = 1'b1;
        s0 = stall_cnt;
        #1;
        checks++;
        if (dut_vec !== V_DEF) $display("FAIL rd_zero_out: got %b expected %b", dut_vec, V_DEF);
        else passes++;
        tick();
        checks++;
        if (stall_cnt !== s0) $display("FAIL rd_zero_stall: got %0d expected %0d", stall_cnt, s0);
        else passes++;
        idle();
    endtask

    task automatic test_trap_branch();
        logic [7:0] f0;
        idle();
        trap = 1'b1; branch = 1'b1;
        f0 = flush_cnt;
        #1;
        checks++;
        if (pc_sel !== 2'b10 || dut_vec !== V_TRAP)
            $display("FAIL trap_branch_out: got %b expected %b", dut_vec, V_TRAP);
        else passes++;
        tick();
        checks++;
        if (state !== 2'b10 || flush_cnt !== f0 + 8'd1)
            $display("FAIL trap_state: got state=%b flush=%0d expected 10/%0d", state, flush_cnt, f0 + 8'd1);
        else passes++;
        trap = 1'b0; branch = 1'b0; ibus_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (if_id_clr !== 1'b1 || dut_vec !== V_IWAIT)
                $display("FAIL tflush_wait[%0d]: got %b expected %b", i, dut_vec, V_IWAIT);
            else passes++;
            tick();
        end
        ibus_ack = 1'b1;
        branch = 1'b1;
        ex_load = 1'b1; ex_rd = 5'd3; rs2 = 5'd3; use2 = 1'b1;
        #1;
        checks++;
        if (dut_vec !== V_DEF) $display("FAIL tflush_release: got %b expected %b", dut_vec, V_DEF);
        else passes++;
        tick();
        checks++;
        if (state !== 2'b00) $display("FAIL tflush_to_run: got %b expected 00", state);
        else passes++;
        branch = 1'b1;
        #1;
        checks++;
        if (dut_vec !== V_BR) $display("FAIL branch_over_lu: got %b expected %b", dut_vec, V_BR);
        else passes++;
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [10:0] ev;
        for (int i = 0; i < 600; i++) begin
            trap     = ($urandom % 16) == 0;
            branch   = ($urandom % 6) == 0;
            dbus_req = (m_state != 2) && (($urandom % 4) == 0);
            dbus_ack = $urandom % 2;
            ibus_ack = ($urandom % 4) != 0;
            ex_load  = $urandom % 2;
            ex_rd    = 5'($urandom % 4);
            rs1      = 5'($urandom % 4);
            rs2      = 5'($urandom % 4);
            use1     = $urandom % 2;
            use2     = $urandom % 2;
            #1;
            ev = rule_vec(cur_rule());
            checks++;
            if (dut_vec !== ev) $display("FAIL random_out[%0d]: got %b expected %b", i, dut_vec, ev);
            else passes++;
            tick();
            checks++;
            if (state !== 2'(m_state) || stall_cnt !== 16'(m_stall) || flush_cnt !== 8'(m_flush))
                $display("FAIL random_regs[%0d]: got %b/%0d/%0d expected %0d/%0d/%0d",
                         i, state, stall_cnt, flush_cnt, m_state, m_stall, m_flush);
            else passes++;
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        dbus_req = 1'b1;
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'b00 || stall_cnt !== 16'd0 || flush_cnt !== 8'd0 || dut_vec !== V_RESET)
            $display("FAIL async_reset_dwait: got state=%b stall=%0d flush=%0d out=%b expected 00/0/0/%b",
                     state, stall_cnt, flush_cnt, dut_vec, V_RESET);
        else passes++;
        m_state = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        trap = 1'b1;
        tick();
        trap = 1'b0;
        #3 rst_n = 1'b0;
        m_state = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        ibus_ack = 1'b0; branch = 1'b1;
        #1;
        checks++;
        if (state !== 2'b00 || dut_vec !== V_BR)
            $display("FAIL async_reset_tflush: got state=%b out=%b expected 00/%b", state, dut_vec, V_BR);
        else passes++;
        tick();
        idle();
    endtask

    task automatic test_flush_saturation();
        do_reset();
        branch = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        checks++;
        if (flush_cnt !== 8'hFE) $display("FAIL flush_pre_sat: got %0d expected 254", flush_cnt);
        else passes++;
        for (int i = 0; i < 46; i++) tick();
        checks++;
        if (flush_cnt !== 8'hFF) $display("FAIL flush_sat: got %0d expected 255", flush_cnt);
        else passes++;
        idle();
    endtask

    task automatic test_stall_saturation();
        do_reset();
        ibus_ack = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
        end
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFE) $display("FAIL stall_pre_sat: got %0d expected 65534", stall_cnt);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
        end
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) $display("FAIL stall_sat: got %0d expected 65535", stall_cnt);
        else passes++;
        idle();
    endtask

    initial begin
        test_reset();
        test_dbus_wait();
        test_load_use();
        test_rd_zero();
        test_trap_branch();
        test_random();
        test_async_reset();
        test_flush_saturation();
        test_stall_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
